logic_op_scheduler: RTL and testbench
=====================================

Name: logic_op_scheduler

Overview:
- Shares one bitwise logic/rotate unit of the 16-bit calculator between two requesters, for example the keypad command decoder and the expression evaluator.
- Arbitrates round-robin, sequences single-cycle bitwise ops and multi-cycle rotates, and returns a tagged result over a valid/ready response channel.

Parameters:
- W, 16, operand/result width; must be a power of 2 and ≥ 2.
- CW, $clog2(W), rotate count width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_op  in  3  requester 0 opcode
- req0_x  in  W  requester 0 operand x
- req0_y  in  W  requester 0 operand y
- req1_valid / req1_ready / req1_op / req1_x / req1_y: same as requester 0, for requester 1
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  W  result
- rsp_id  out  1  requester that issued the command
- rsp_err  out  1  illegal/unsupported opcode flag
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
  - 6 NOT x (y ignored)
  - 7 ROTL x by y[CW-1:0]
- States: IDLE, ROT, RESP.
- IDLE, arbitration:
  - grant = the only valid requester; if both are valid, the one not granted last (rr pointer).
  - reqN_ready = (state==IDLE) && grantN. Ready is combinational from valid and the pointer; at most one ready per cycle.
  - Handshake on valid&&ready latches op, x, y and id; the rr pointer updates to the granted id.
- Ops 0-6: result registered at acceptance; next state RESP. rsp_valid rises the cycle after acceptance (latency 1).
- ROTL:
  - count = y[CW-1:0]; upper y bits are ignored.
  - count==0: behaves as ops 0-6, rsp_data = x.
  - count≠0: enter ROT. Rotate the working register left by 1 bit per cycle and decrement count. Go to RESP when count reaches 0.
  - rsp_valid rises count+1 cycles after acceptance. Example: count=15 gives latency 16.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err stay stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE. No acceptance happens in the same cycle, so a new command can be accepted at the earliest 1 cycle later. Peak throughput is one op per 2 cycles.
- Requesters must hold valid and payload until ready; the block does not check this.
- Reset, including during ROT or RESP:
  - state=IDLE; the in-flight op is discarded.
  - rr pointer set so req0 wins the first tie.
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, both ready=0.
- rsp_err=0 for all supported opcodes.

Optional Feature:
- Macro LOGIC_OP_SCHEDULER_ROTATE_EN.
- Defined: ROTL is supported as above; the ROT state and counter exist.
- Undefined:
  - No ROT state or counter is built.
  - Opcode 7 is still accepted and answered with latency 1: rsp_data=0, rsp_err=1.
  - ROT is unreachable.

Decomposition:
- Package logic_op_scheduler_pkg holds:
  - opcode localparams OP_AND…OP_ROTL
  - state encoding ST_IDLE/ST_ROT/ST_RESP
  - default width constant 16
- One sub-module, logic_unit_comb: purely combinational, taking op and x,y and producing the opcode 0-6 result. It is instantiated once and is shared by both requesters.

Test Plan:
- req0 AND x=16'hF0F0, y=16'h3C3C, rsp_ready=1 -> rsp_valid 1 cycle after accept; rsp_data=16'h3030, rsp_id=0, rsp_err=0.
- req0 and req1 both valid with XOR, held for 4 commands, after reset -> grants alternate 0,1,0,1; req1 XOR 16'hFFFF^16'h00FF gives 16'hFF00.
- req1 ROTL x=16'h8001, y=16'h0004 -> rsp_valid 5 cycles after accept; rsp_data=16'h0018, busy high throughout.
- RESP held with rsp_ready=0 for 3 cycles while req0 is valid -> rsp outputs stable, req0_ready=0; accept occurs 1 cycle after the rsp handshake.
- rst pulsed mid-ROT (count=10, after 3 cycles) -> rsp_valid never rises for that op; all outputs 0; next req1-only command is granted immediately.
- Build without LOGIC_OP_SCHEDULER_ROTATE_EN, opcode 7 -> latency 1, rsp_data=0, rsp_err=1; NOT x=16'h1234 gives 16'hEDCB.

Source files
------------

// File: rtl/logic_op_scheduler_pkg.sv
// Shared opcodes, FSM state encoding and default width for the logic/rotate scheduler.
package logic_op_scheduler_pkg;

    localparam int DEF_W = 16;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_ROTL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit_comb.sv
// Purely combinational bitwise unit for opcodes 0-6; zero for anything else.
module logic_unit_comb
    import logic_op_scheduler_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] res
);

    always_comb begin
        res = '0;
        case (op)
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_XOR:  res = x ^ y;
            OP_NAND: res = ~(x & y);
            OP_NOR:  res = ~(x | y);
            OP_XNOR: res = ~(x ^ y);
            OP_NOT:  res = ~x;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// Round-robin share of one logic/rotate unit between two requesters; latency 1 (ROTL: count+1), response held until rsp_ready.
// Rotate support is built only with LOGIC_OP_SCHEDULER_ROTATE_EN; otherwise opcode 7 answers rsp_err=1 with latency 1.
module logic_op_scheduler
    import logic_op_scheduler_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_id,
    output logic         rsp_err,
    output logic         busy
);

`ifdef LOGIC_OP_SCHEDULER_ROTATE_EN
    localparam int CW = $clog2(W);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    state_t       state_q, state_d;
    logic         last_q, last_d;
    logic [W-1:0] res_q, res_d;
    logic         id_q, id_d;
    logic         err_q, err_d;

    logic         grant0, grant1, accept;
    logic [2:0]   sel_op;
    logic [W-1:0] sel_x, sel_y, lu_res;

    // last_q holds the id granted most recently; a tie goes to the other one.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
    end

    assign req0_ready = !rst && (state_q == ST_IDLE) && grant0;
    assign req1_ready = !rst && (state_q == ST_IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        sel_op = grant1 ? req1_op : req0_op;
        sel_x  = grant1 ? req1_x  : req0_x;
        sel_y  = grant1 ? req1_y  : req0_y;
    end

    logic_unit_comb #(.W(W)) u_logic_unit (
        .op  (sel_op),
        .x   (sel_x),
        .y   (sel_y),
        .res (lu_res)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        res_d   = res_q;
        id_d    = id_q;
        err_d   = err_q;
`ifdef LOGIC_OP_SCHEDULER_ROTATE_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d    = grant1;
                    last_d  = grant1;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                    if (sel_op != OP_ROTL) begin
                        res_d = lu_res;
                    end else begin
`ifdef LOGIC_OP_SCHEDULER_ROTATE_EN
                        res_d = sel_x;
                        if (sel_y[CW-1:0] != '0) begin
                            cnt_d   = sel_y[CW-1:0];
                            state_d = ST_ROT;
                        end
`else
                        res_d = '0;
                        err_d = 1'b1;
`endif
                    end
                end
            end
`ifdef LOGIC_OP_SCHEDULER_ROTATE_EN
            ST_ROT: begin
                res_d = {res_q[W-2:0], res_q[W-1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            res_q   <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            res_q   <= res_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

`ifdef LOGIC_OP_SCHEDULER_ROTATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Response fields read as zero outside RESP so a discarded op never leaks out.
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_valid ? res_q : '0;
    assign rsp_id    = rsp_valid ? id_q  : 1'b0;
    assign rsp_err   = rsp_valid ? err_q : 1'b0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Randomised bench for logic_op_scheduler against a transaction-level model, plus directed literal checks.
module tb_logic_op_scheduler;

    localparam int W = 16;
`ifdef LOGIC_OP_SCHEDULER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [15:0] rsp_data;

    logic_op_scheduler #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endtask

    // Reference semantics of one command: result, error flag, response latency.
    function automatic void ref_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                                   output logic [15:0] r, output logic e, output int lat);
        int k;
        e = 1'b0;
        lat = 1;
        r = '0;
        case (op)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = ~(x & y);
            3'd4: r = ~(x | y);
            3'd5: r = ~(x ^ y);
            3'd6: r = ~x;
            default: begin
                if (ROT_EN) begin
                    k = int'(y) % W;
                    r = (k == 0) ? x : ((x << k) | (x >> (W - k)));
                    lat = k + 1;
                end else begin
                    e = 1'b1;
                end
            end
        endcase
    endfunction

    // Model state: one command in flight, due at a known cycle.
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_last = 1;
    int          m_due = 0;
    logic [15:0] m_dat;
    logic        m_id, m_err;
    bit          prev_rv = 0;
    int          acc_cnt = 0, acc_cyc = 0, hs_cyc = 0;
    int          rise_cnt = 0, rise_cyc = 0;
    bit          acc_ids[$];
    bit          rise_ids[$];
    logic [15:0] rise_dats[$];
    logic        rise_errs[$];

    always @(negedge clk) begin
        logic g0, g1, rv, e;
        logic [15:0] r;
        int lat;
        cyc++;
        if (rst) begin
            m_busy = 0;
            m_last = 1;
            prev_rv = 0;
            chk("reset_outputs", {10'd0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy, rsp_data},
                32'd0);
        end else begin
            g0 = !m_busy && req0_valid && (!req1_valid || m_last);
            g1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            rv = m_busy && (cyc >= m_due);
            chk("req0_ready", req0_ready, g0);
            chk("req1_ready", req1_ready, g1);
            chk("rsp_valid", rsp_valid, rv);
            chk("busy", busy, m_busy);
            if (rv) begin
                chk("rsp_data", rsp_data, m_dat);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_err", rsp_err, m_err);
            end
            if (rsp_valid && !prev_rv) begin
                rise_cnt++;
                rise_cyc = cyc;
                rise_ids.push_back(rsp_id);
                rise_dats.push_back(rsp_data);
                rise_errs.push_back(rsp_err);
            end
            prev_rv = rsp_valid;
            if (rv && rsp_ready) begin
                m_busy = 0;
                hs_cyc = cyc;
            end else if (g0 || g1) begin
                if (g1) ref_op(req1_op, req1_x, req1_y, r, e, lat);
                else    ref_op(req0_op, req0_x, req0_y, r, e, lat);
                m_dat = r;
                m_err = e;
                m_id = g1;
                m_last = g1;
                m_busy = 1;
                m_due = cyc + lat;
                acc_cnt++;
                acc_cyc = cyc;
                acc_ids.push_back(g1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit id, output int waited);
        bit got;
        got = 0;
        waited = 0;
        while (!got && waited < 400) begin
            tick();
            if ((id ? req1_ready : req0_ready) == 1'b1) got = 1;
            else waited++;
        end
        if (!got) timeout("wait_ready");
        step();
    endtask

    task automatic issue(input bit id, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                         output int waited);
        step();
        if (id) begin
            req1_op = op; req1_x = x; req1_y = y; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_x = x; req0_y = y; req0_valid = 1'b1;
        end
        wait_ready(id, waited);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_rise(input int base);
        int n;
        n = 0;
        while (rise_cnt <= base && n < 100) begin
            tick();
            n++;
        end
        if (rise_cnt <= base) timeout("wait_rise");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick();
        while ((busy || rsp_valid) && n < 200) begin
            tick();
            n++;
        end
        if (busy || rsp_valid) timeout("wait_idle");
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    bit rnd_on = 0;
    initial forever begin
        step();
        if (rnd_on) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, base, rb, n;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_op = '0; req1_op = '0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // AND, latency 1
        rb = rise_cnt;
        issue(0, 3'd0, 16'hF0F0, 16'h3C3C, w);
        wait_rise(rb);
        chk("and_latency", rise_cyc - acc_cyc, 1);
        chk("and_data", rise_dats[rb], 16'h3030);
        chk("and_id", rise_ids[rb], 0);
        chk("and_err", rise_errs[rb], 0);
        wait_idle();

        // Both requesters held with XOR: grants alternate from reset
        do_reset();
        step();
        base = acc_cnt;
        rb = rise_cnt;
        req0_op = 3'd2; req0_x = 16'hAAAA; req0_y = 16'h0F0F; req0_valid = 1'b1;
        req1_op = 3'd2; req1_x = 16'hFFFF; req1_y = 16'h00FF; req1_valid = 1'b1;
        n = 0;
        while (acc_cnt < base + 4 && n < 100) begin
            tick();
            n++;
        end
        if (acc_cnt < base + 4) timeout("alternate_accepts");
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 4; i++) chk("alternate_grant", acc_ids[base + i], i % 2);
        chk("xor_req1_id", rise_ids[rb + 1], 1);
        chk("xor_req1_data", rise_dats[rb + 1], 16'hFF00);
        chk("xor_req0_data", rise_dats[rb], 16'hA5A5);

        // ROTL by 4 from requester 1
        rb = rise_cnt;
        issue(1, 3'd7, 16'h8001, 16'h0004, w);
        wait_rise(rb);
        chk("rotl_latency", rise_cyc - acc_cyc, ROT_EN ? 5 : 1);
        chk("rotl_data", rise_dats[rb], ROT_EN ? 16'h0018 : 16'h0000);
        chk("rotl_err", rise_errs[rb], ROT_EN ? 0 : 1);
        wait_idle();

        // NOT ignores y
        rb = rise_cnt;
        issue(0, 3'd6, 16'h1234, 16'h5555, w);
        wait_rise(rb);
        chk("not_data", rise_dats[rb], 16'hEDCB);
        wait_idle();

        // Response held under backpressure while req0 waits
        step();
        rsp_ready = 1'b0;
        rb = rise_cnt;
        issue(0, 3'd1, 16'h1234, 16'h00F0, w);
        wait_rise(rb);
        step();
        req0_op = 3'd5; req0_x = 16'h0F0F; req0_y = 16'h00FF; req0_valid = 1'b1;
        repeat (3) step();
        rsp_ready = 1'b1;
        wait_ready(0, w);
        req0_valid = 1'b0;
        chk("hold_gap", acc_cyc - hs_cyc, 1);
        chk("hold_data", rise_dats[rb], 16'h12F4);
        wait_idle();

        // Reset in the middle of a long rotate discards it
        step();
        rsp_ready = 1'b0;
        rb = rise_cnt;
        issue(0, 3'd7, 16'($urandom), 16'h000A, w);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tick();
        chk("reset_discard", rise_cnt - rb, ROT_EN ? 0 : 1);
        step();
        rsp_ready = 1'b1;
        rb = rise_cnt;
        issue(1, 3'd1, 16'h0F00, 16'h00F0, w);
        chk("post_reset_grant_wait", w, 0);
        wait_rise(rb);
        chk("post_reset_id", rise_ids[rb], 1);
        chk("post_reset_data", rise_dats[rb], 16'h0FF0);
        wait_idle();

        // Randomised traffic from both requesters with random backpressure
        step();
        rnd_on = 1;
        fork
            begin
                int wa;
                for (int i = 0; i < 120; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    issue(0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), wa);
                end
            end
            begin
                int wb;
                for (int j = 0; j < 120; j++) begin
                    repeat ($urandom_range(0, 3)) step();
                    issue(1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), wb);
                end
            end
        join
        rnd_on = 0;
        step();
        rsp_ready = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
